// File: rtl/segdisplay_scan_n.sv
// Multiplexed 7-segment driver for NUM_DIGITS common-anode digits.
// Built-in prescaler, anti-ghosting guard interval, hex decode, per-digit
// decimal point and blanking. Optional digit blinking is compiled in when
// the macro SEG_BLINK_EN is defined (adds the blink_in port).
// All pins are registered from the next-state counter/index so that
// an/seg/dp always agree with cnt/scan_idx.
module segdisplay_scan_n #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned SCAN_DIV     = 1024,
   parameter int unsigned GUARD_CYCLES = 16,
   parameter int unsigned BLINK_FRAMES = 64,
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    segclk,
   input  logic                    clr,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
`ifdef SEG_BLINK_EN
   input  logic [NUM_DIGITS-1:0]   blink_in,
`endif
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [IDX_W-1:0]        scan_idx
);

   localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] GUARD    = CNT_W'(GUARD_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   // Elaboration-time parameter sanity checks
   if (NUM_DIGITS < 2 || NUM_DIGITS > 16) begin : g_bad_digits
      $error("NUM_DIGITS must be in 2..16");
   end
   if (SCAN_DIV < 2 || GUARD_CYCLES >= SCAN_DIV) begin : g_bad_div
      $error("SCAN_DIV must be >= 2 and GUARD_CYCLES < SCAN_DIV");
   end
   if (BLINK_FRAMES < 1) begin : g_bad_blink
      $error("BLINK_FRAMES must be >= 1");
   end

   logic [CNT_W-1:0]      cnt, cnt_next;
   logic [IDX_W-1:0]      idx_next;
   logic                  slot_wrap;
   logic                  in_guard;
   logic                  hide;
   logic [3:0]            nibble;
   logic [NUM_DIGITS-1:0] an_next;
   logic [6:0]            seg_next;
   logic                  dp_next;

   // Active-high segment pattern {g,f,e,d,c,b,a} for every nibble value
   function automatic logic [6:0] hex_pattern(input logic [3:0] v);
      logic [6:0] p;
      case (v)
         4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
         4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
         4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
         4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
      endcase
      return p;
   endfunction

   // Prescaler and digit index next-state; index wraps at NUM_DIGITS-1
   always_comb begin
      slot_wrap = (cnt == CNT_LAST);
      cnt_next  = slot_wrap ? '0 : cnt + 1'b1;
      idx_next  = scan_idx;
      if (slot_wrap) begin
         idx_next = (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
      end
   end

   // Guard interval: all anodes off during the first GUARD_CYCLES of a slot
   if (GUARD_CYCLES == 0) begin : g_no_guard
      always_comb in_guard = 1'b0;
   end else begin : g_guard
      always_comb in_guard = (cnt_next < GUARD);
   end

`ifdef SEG_BLINK_EN
   localparam int unsigned FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FRAMES - 1);

   logic [FR_W-1:0] frame, frame_next;
   logic            phase, phase_next;

   // Frame counter advances on each full scan; phase flips when it wraps
   always_comb begin
      frame_next = frame;
      phase_next = phase;
      if (slot_wrap && scan_idx == IDX_LAST) begin
         if (frame == FR_LAST) begin
            frame_next = '0;
            phase_next = ~phase;
         end else begin
            frame_next = frame + 1'b1;
         end
      end
   end

   // Blink state register
   always_ff @(posedge segclk or negedge clr) begin
      if (!clr) begin
         frame <= '0;
         phase <= 1'b0;
      end else begin
         frame <= frame_next;
         phase <= phase_next;
      end
   end

   // Blanking uses next-state phase so it stays coherent with scan_idx
   always_comb hide = blank_in[idx_next] | (phase_next & blink_in[idx_next]);
`else
   // Per-digit blanking of the digit about to be selected
   always_comb hide = blank_in[idx_next];
`endif

   // Pin values for the digit selected after this edge
   always_comb begin
      nibble  = digits_in[{idx_next, 2'b00} +: 4];
      an_next = '1;
      if (!in_guard) begin
         an_next[idx_next] = 1'b0;
      end
      seg_next = hide ? '1 : ~hex_pattern(nibble);
      dp_next  = hide | ~dp_in[idx_next];
   end

   // Scan state and registered display pins
   always_ff @(posedge segclk or negedge clr) begin
      if (!clr) begin
         cnt      <= '0;
         scan_idx <= '0;
         an       <= '1;
         seg      <= '1;
         dp       <= 1'b1;
      end else begin
         cnt      <= cnt_next;
         scan_idx <= idx_next;
         an       <= an_next;
         seg      <= seg_next;
         dp       <= dp_next;
      end
   end

endmodule

// File: tb/tb_segdisplay_scan_n.sv
// Self-checking bench for segdisplay_scan_n: three configurations
// (4x4 guard 1, 4x4 guard 0, 6x2 guard 1) compared against a cycle-count
// reference model. Blink scenario is included when SEG_BLINK_EN is defined.
module tb_segdisplay_scan_n;

`ifdef SEG_BLINK_EN
   localparam bit BLINK_ON = 1'b1;
`else
   localparam bit BLINK_ON = 1'b0;
`endif

   logic segclk = 1'b0;
   logic clr    = 1'b0;

   logic [15:0] dig4;
   logic [3:0]  dp4, bl4, bk4;
   logic [23:0] dig6;
   logic [5:0]  dp6, bl6, bk6;

   logic [6:0] seg_a, seg_b, seg_c;
   logic       dp_a, dp_b, dp_c;
   logic [3:0] an_a, an_b;
   logic [5:0] an_c;
   logic [1:0] idx_a, idx_b;
   logic [2:0] idx_c;

   int checks   = 0;
   int failures = 0;
   int t        = 0;

   logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   always #5 segclk = ~segclk;

   segdisplay_scan_n #(.NUM_DIGITS(4), .SCAN_DIV(4), .GUARD_CYCLES(1), .BLINK_FRAMES(2)) u_a (
      .segclk(segclk), .clr(clr), .digits_in(dig4), .dp_in(dp4), .blank_in(bl4),
`ifdef SEG_BLINK_EN
      .blink_in(bk4),
`endif
      .seg(seg_a), .dp(dp_a), .an(an_a), .scan_idx(idx_a));

   segdisplay_scan_n #(.NUM_DIGITS(4), .SCAN_DIV(4), .GUARD_CYCLES(0), .BLINK_FRAMES(2)) u_b (
      .segclk(segclk), .clr(clr), .digits_in(dig4), .dp_in(dp4), .blank_in(bl4),
`ifdef SEG_BLINK_EN
      .blink_in(bk4),
`endif
      .seg(seg_b), .dp(dp_b), .an(an_b), .scan_idx(idx_b));

   segdisplay_scan_n #(.NUM_DIGITS(6), .SCAN_DIV(2), .GUARD_CYCLES(1), .BLINK_FRAMES(2)) u_c (
      .segclk(segclk), .clr(clr), .digits_in(dig6), .dp_in(dp6), .blank_in(bl6),
`ifdef SEG_BLINK_EN
      .blink_in(bk6),
`endif
      .seg(seg_c), .dp(dp_c), .an(an_c), .scan_idx(idx_c));

   // Reference: display state after tt edges since reset release
   function automatic void model(input int n, input int div, input int g, input int bf,
                                 input int tt, input logic [63:0] dig,
                                 input logic [15:0] dpv, input logic [15:0] blk,
                                 input logic [15:0] bkv,
                                 output logic [15:0] an_e, output logic [6:0] seg_e,
                                 output logic dp_e, output int idx_e);
      int   cnt;
      logic hidden;
      logic [3:0] nib;
      cnt    = tt % div;
      idx_e  = (tt / div) % n;
      an_e   = 16'hFFFF;
      if (cnt >= g) an_e[idx_e] = 1'b0;
      hidden = blk[idx_e] | (BLINK_ON && bkv[idx_e] && (((tt / (div * n)) / bf) % 2 == 1));
      nib    = dig[idx_e*4 +: 4];
      seg_e  = hidden ? 7'h7F : ~pat[nib];
      dp_e   = hidden ? 1'b1 : ~dpv[idx_e];
   endfunction

   // Advance one edge, then move to the sampling point
   task automatic step();
      @(posedge segclk);
      t++;
      @(negedge segclk);
   endtask

   // Pulse reset and release it at a falling edge
   task automatic restart();
      @(negedge segclk);
      clr = 1'b0;
      @(negedge segclk);
      clr = 1'b1;
      t = 0;
   endtask

   task automatic test_reset();
      clr  = 1'b0;
      dig4 = 16'h3210; dp4 = '1; bl4 = '0; bk4 = '0;
      dig6 = 24'h543210; dp6 = '1; bl6 = '0; bk6 = '0;
      repeat (10) @(posedge segclk);
      @(negedge segclk);
      checks += 7;
      if (an_a !== 4'b1111) begin failures++; $display("FAIL reset_an_a got=%b exp=1111", an_a); end
      if (seg_a !== 7'h7F) begin failures++; $display("FAIL reset_seg_a got=%h exp=7f", seg_a); end
      if (dp_a !== 1'b1) begin failures++; $display("FAIL reset_dp_a got=%b exp=1", dp_a); end
      if (idx_a !== 2'd0) begin failures++; $display("FAIL reset_idx_a got=%0d exp=0", idx_a); end
      if (an_b !== 4'b1111) begin failures++; $display("FAIL reset_an_b got=%b exp=1111", an_b); end
      if (an_c !== 6'b111111) begin failures++; $display("FAIL reset_an_c got=%b exp=111111", an_c); end
      if (seg_c !== 7'h7F || dp_c !== 1'b1 || idx_c !== 3'd0) begin
         failures++; $display("FAIL reset_c got seg=%h dp=%b idx=%0d exp seg=7f dp=1 idx=0", seg_c, dp_c, idx_c);
      end
   endtask

   task automatic test_scan();
      logic [15:0] ae; logic [6:0] se; logic de; int ie;
      dig4 = 16'h3210; dp4 = '0; bl4 = '0; bk4 = '0;
      restart();
      repeat (20) begin
         step();
         model(4, 4, 1, 2, t, 64'(dig4), 16'(dp4), 16'(bl4), 16'(bk4), ae, se, de, ie);
         checks += 4;
         if (an_a !== ae[3:0]) begin failures++; $display("FAIL scan_an t=%0d got=%b exp=%b", t, an_a, ae[3:0]); end
         if (seg_a !== se) begin failures++; $display("FAIL scan_seg t=%0d got=%h exp=%h", t, seg_a, se); end
         if (dp_a !== de) begin failures++; $display("FAIL scan_dp t=%0d got=%b exp=%b", t, dp_a, de); end
         if (idx_a !== 2'(ie)) begin failures++; $display("FAIL scan_idx t=%0d got=%0d exp=%0d", t, idx_a, ie); end
      end
   endtask

   task automatic test_mid_reset();
      @(posedge segclk);
      #2 clr = 1'b0;
      #1;
      checks += 3;
      if (an_a !== 4'b1111 || seg_a !== 7'h7F || dp_a !== 1'b1 || idx_a !== 2'd0) begin
         failures++; $display("FAIL midreset_a got an=%b seg=%h dp=%b idx=%0d exp an=1111 seg=7f dp=1 idx=0", an_a, seg_a, dp_a, idx_a);
      end
      if (an_b !== 4'b1111 || seg_b !== 7'h7F || dp_b !== 1'b1) begin
         failures++; $display("FAIL midreset_b got an=%b seg=%h dp=%b exp an=1111 seg=7f dp=1", an_b, seg_b, dp_b);
      end
      if (an_c !== 6'b111111 || seg_c !== 7'h7F || idx_c !== 3'd0) begin
         failures++; $display("FAIL midreset_c got an=%b seg=%h idx=%0d exp an=111111 seg=7f idx=0", an_c, seg_c, idx_c);
      end
      @(negedge segclk);
      clr = 1'b1;
   endtask

   task automatic test_hex();
      logic [15:0] ae; logic [6:0] se; logic de; int ie;
      dig4 = 16'hFEDC; dp4 = '0; bl4 = '0; bk4 = '0;
      restart();
      repeat (16) begin
         step();
         model(4, 4, 1, 2, t, 64'(dig4), 16'(dp4), 16'(bl4), 16'(bk4), ae, se, de, ie);
         checks++;
         if (seg_a !== se) begin failures++; $display("FAIL hex_seg t=%0d got=%h exp=%h", t, seg_a, se); end
         model(4, 4, 0, 2, t, 64'(dig4), 16'(dp4), 16'(bl4), 16'(bk4), ae, se, de, ie);
         checks += 3;
         if (an_b !== ae[3:0]) begin failures++; $display("FAIL noguard_an t=%0d got=%b exp=%b", t, an_b, ae[3:0]); end
         if (an_b === 4'b1111) begin failures++; $display("FAIL noguard_allon t=%0d got=%b exp=not 1111", t, an_b); end
         if (seg_b !== se) begin failures++; $display("FAIL noguard_seg t=%0d got=%h exp=%h", t, seg_b, se); end
      end
   endtask

   task automatic test_dp_blank();
      logic [15:0] ae; logic [6:0] se; logic de; int ie;
      dig4 = 16'h3210; dp4 = 4'b0100; bl4 = 4'b0001; bk4 = '0;
      restart();
      repeat (16) begin
         step();
         model(4, 4, 1, 2, t, 64'(dig4), 16'(dp4), 16'(bl4), 16'(bk4), ae, se, de, ie);
         checks += 3;
         if (an_a !== ae[3:0]) begin failures++; $display("FAIL dpblank_an t=%0d got=%b exp=%b", t, an_a, ae[3:0]); end
         if (seg_a !== se) begin failures++; $display("FAIL dpblank_seg t=%0d got=%h exp=%h", t, seg_a, se); end
         if (dp_a !== de) begin failures++; $display("FAIL dpblank_dp t=%0d got=%b exp=%b", t, dp_a, de); end
      end
   endtask

   task automatic test_wide();
      logic [15:0] ae; logic [6:0] se; logic de; int ie;
      dig6 = 24'h9A5F07; dp6 = 6'b101010; bl6 = '0; bk6 = '0;
      restart();
      repeat (30) begin
         step();
         model(6, 2, 1, 2, t, 64'(dig6), 16'(dp6), 16'(bl6), 16'(bk6), ae, se, de, ie);
         checks += 4;
         if (idx_c !== 3'(ie)) begin failures++; $display("FAIL wide_idx t=%0d got=%0d exp=%0d", t, idx_c, ie); end
         if (an_c !== ae[5:0]) begin failures++; $display("FAIL wide_an t=%0d got=%b exp=%b", t, an_c, ae[5:0]); end
         if ($countones(~an_c) > 1) begin failures++; $display("FAIL wide_onehot t=%0d got=%b exp=at most one low", t, an_c); end
         if (seg_c !== se || dp_c !== de) begin
            failures++; $display("FAIL wide_segdp t=%0d got seg=%h dp=%b exp seg=%h dp=%b", t, seg_c, dp_c, se, de);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] ae; logic [6:0] se; logic de; int ie;
      restart();
      repeat (300) begin
         step();
         model(4, 4, 1, 2, t, 64'(dig4), 16'(dp4), 16'(bl4), 16'(bk4), ae, se, de, ie);
         checks += 2;
         if (an_a !== ae[3:0] || idx_a !== 2'(ie)) begin
            failures++; $display("FAIL rand_a_scan t=%0d got an=%b idx=%0d exp an=%b idx=%0d", t, an_a, idx_a, ae[3:0], ie);
         end
         if (seg_a !== se || dp_a !== de) begin
            failures++; $display("FAIL rand_a_segdp t=%0d got seg=%h dp=%b exp seg=%h dp=%b", t, seg_a, dp_a, se, de);
         end
         model(4, 4, 0, 2, t, 64'(dig4), 16'(dp4), 16'(bl4), 16'(bk4), ae, se, de, ie);
         checks++;
         if (an_b !== ae[3:0] || seg_b !== se || dp_b !== de) begin
            failures++; $display("FAIL rand_b t=%0d got an=%b seg=%h dp=%b exp an=%b seg=%h dp=%b", t, an_b, seg_b, dp_b, ae[3:0], se, de);
         end
         model(6, 2, 1, 2, t, 64'(dig6), 16'(dp6), 16'(bl6), 16'(bk6), ae, se, de, ie);
         checks++;
         if (an_c !== ae[5:0] || seg_c !== se || dp_c !== de || idx_c !== 3'(ie)) begin
            failures++; $display("FAIL rand_c t=%0d got an=%b seg=%h dp=%b idx=%0d exp an=%b seg=%h dp=%b idx=%0d",
                                 t, an_c, seg_c, dp_c, idx_c, ae[5:0], se, de, ie);
         end
         dig4 = 16'($urandom);
         dp4  = 4'($urandom);
         bl4  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         bk4  = 4'($urandom);
         dig6 = 24'($urandom);
         dp6  = 6'($urandom);
         bl6  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b000000;
         bk6  = 6'($urandom);
      end
   endtask

`ifdef SEG_BLINK_EN
   task automatic test_blink();
      logic [15:0] ae; logic [6:0] se; logic de; int ie;
      dig4 = 16'h3210; dp4 = 4'b1111; bl4 = '0; bk4 = 4'b0010;
      restart();
      repeat (100) begin
         step();
         model(4, 4, 1, 2, t, 64'(dig4), 16'(dp4), 16'(bl4), 16'(bk4), ae, se, de, ie);
         checks += 2;
         if (seg_a !== se) begin failures++; $display("FAIL blink_seg t=%0d got=%h exp=%h", t, seg_a, se); end
         if (dp_a !== de) begin failures++; $display("FAIL blink_dp t=%0d got=%b exp=%b", t, dp_a, de); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_scan();
      test_mid_reset();
      test_hex();
      test_dp_blank();
      test_wide();
`ifdef SEG_BLINK_EN
      test_blink();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/segdisplay_scan_n.md
Name: segdisplay_scan_n

Overview:
- Parametrised successor to the fixed 4-digit 7-segment multiplexer, for multi-digit common-anode displays.
- Scans NUM_DIGITS digits with a built-in prescaler and a programmable anti-ghosting blank interval.
- Provides full hex decode (0-F), per-digit decimal point and per-digit blanking.
- Sits between the datapath (packed BCD/hex nibbles) and the board's seg/an/dp pins.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; legal range 2..16.
- SCAN_DIV, 1024: segclk cycles per digit slot; must be ≥ 2.
- GUARD_CYCLES, 16: cycles at the start of each slot with all anodes off; must be < SCAN_DIV; 0 disables the guard.
- BLINK_FRAMES, 64: full scan frames per blink half-period; used only with SEG_BLINK_EN.

Ports:
- segclk, input, 1: display clock.
- clr, input, 1: reset, asynchronous, active-low.
- digits_in, input, 4*NUM_DIGITS: digit i is bits [4i+3:4i]; digit 0 is the rightmost.
- dp_in, input, NUM_DIGITS: 1 lights the decimal point of digit i.
- blank_in, input, NUM_DIGITS: 1 blanks digit i (segments and dp off).
- blink_in, input, NUM_DIGITS: 1 blinks digit i. Present only with SEG_BLINK_EN.
- seg, output, 7: {g,f,e,d,c,b,a}, active-low, registered.
- dp, output, 1: decimal point, active-low, registered.
- an, output, NUM_DIGITS: anode enables, active-low, registered, at most one bit low.
- scan_idx, output, clog2(NUM_DIGITS) (minimum 1): index of the digit currently selected.

Behaviour:
- Reset (clr=0, asynchronous): cnt=0, scan_idx=0, an=all 1, seg=7'h7F, dp=1, blink state cleared. Outputs take these values immediately, including when reset is asserted mid-slot.
- Prescaler cnt counts 0..SCAN_DIV-1 on every segclk edge and wraps to 0.
- On the wrap edge, scan_idx advances by 1. From NUM_DIGITS-1 it wraps to 0; non-power-of-2 counts never visit illegal indices.
- All outputs are registered from the next-state cnt/scan_idx, so an/seg/dp are always coherent with the cnt/scan_idx registers (zero skew).
- an:
  - all 1 while cnt < GUARD_CYCLES;
  - otherwise bit scan_idx = 0 and all other bits = 1.
- seg = ~pattern(nibble[scan_idx]). Active-high patterns:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- dp = ~dp_in[scan_idx].
- blank_in[scan_idx]=1 forces seg=7F and dp=1. an is still driven, so scan timing is unchanged.
- Inputs are sampled live: a change to digits_in/dp_in/blank_in is visible on seg/dp one edge later if that digit is currently selected, otherwise in its next slot.
- Frame = NUM_DIGITS*SCAN_DIV cycles. Each digit is enabled for SCAN_DIV-GUARD_CYCLES cycles per frame.
- No X propagation: every nibble value has a defined pattern, and there is no default blanking of values ≥ 10.

Optional Feature:
- Macro SEG_BLINK_EN.
- Defined:
  - adds input blink_in plus a frame counter, 0..BLINK_FRAMES-1;
  - the counter increments when scan_idx wraps NUM_DIGITS-1 -> 0;
  - blink_phase toggles each time the counter wraps;
  - while blink_phase=1, a digit with blink_in=1 is treated as blanked;
  - blink_phase resets to 0 (digit visible).
- Undefined: blink_in port and counter are absent; BLINK_FRAMES is ignored; behaviour is otherwise identical.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, GUARD_CYCLES=1 unless noted):
- Reset, then hold clr=0 for 10 edges -> an=4'b1111, seg=7'h7F, dp=1, scan_idx=0. Assert clr=0 mid-slot -> outputs return to reset values without waiting for an edge.
- digits_in=16'h3210, release reset -> per 4-cycle slot: an=1111 for 1 cycle, then 1110 for 3 cycles with seg=~3F; next slot an=1101 with seg=~06; and so on. After 16 cycles, back to digit 0.
- digits_in=16'hFEDC -> seg values ~39, ~5E, ~79, ~71 in digits 0..3. GUARD_CYCLES=0 -> an is never all 1 after reset.
- dp_in=4'b0100, blank_in=4'b0001 -> dp=0 only in the slot with an=1011. Digit-0 slot shows seg=7F, dp=1, an=1110.
- NUM_DIGITS=6, SCAN_DIV=2 -> scan_idx sequence 0..5 then wraps to 0. an is one-hot-low over 6 bits, never all low.
- SEG_BLINK_EN, BLINK_FRAMES=2, blink_in=4'b0010 -> digit 1 is visible for 2 frames (32 cycles), blanked for 2 frames, then visible again. Other digits are never blanked.
